// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter
//   Registered arbiter for WIDTH requesters. Selectable fixed (bit 0
//   highest) or round-robin priority. The current owner keeps the grant
//   while it requests. If others are waiting, the owner is rotated out
//   after MAX_HOLD cycles of ownership. MAX_HOLD = 0 disables rotation.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          request vector, bit i = requester i
//   rr_en        1 = round-robin priority, 0 = fixed priority
//   grant        registered one-hot grant, or all-zero
//   grant_valid  OR of grant
//   grant_id     binary index of the granted bit, 0 when idle
module rr_priority_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic             rr_en,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id
);

    localparam int          HC_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned WU       = WIDTH;
    localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic {
        S_IDLE,
        S_OWNED
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_grant;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_ptr;
    logic [HC_W-1:0]  r_hold;

    state_t           w_nxt_state;
    logic [WIDTH-1:0] w_nxt_grant;
    logic [ID_W-1:0]  w_nxt_id;
    logic [ID_W-1:0]  w_nxt_ptr;
    logic [HC_W-1:0]  w_nxt_hold;

    logic [WIDTH-1:0] w_cand;
    logic             w_fix_any;
    logic [ID_W-1:0]  w_fix_idx;
    logic             w_rr_any;
    logic [ID_W-1:0]  w_rr_idx;
    logic [ID_W-1:0]  w_win_idx;
    logic             w_owner_req;
    logic             w_decide;

    // Candidates are always the requesters other than the current owner.
    // In IDLE the grant is zero, so this is plain req. On a release the
    // owner's bit is already low. On a forced rotation the owner must be
    // excluded.
    always_comb begin
        w_cand    = req & ~r_grant;
        w_fix_any = 1'b0;
        w_fix_idx = '0;
        for (int unsigned i = 0; i < WU; i++) begin
            if (!w_fix_any && w_cand[ID_W'(i)]) begin
                w_fix_any = 1'b1;
                w_fix_idx = ID_W'(i);
            end
        end
        // Round-robin search starts just after the last winner and wraps.
        w_rr_any = 1'b0;
        w_rr_idx = '0;
        for (int unsigned k = 1; k <= WU; k++) begin
            if (!w_rr_any && w_cand[ID_W'((32'(r_ptr) + k) % WU)]) begin
                w_rr_any = 1'b1;
                w_rr_idx = ID_W'((32'(r_ptr) + k) % WU);
            end
        end
        w_win_idx = rr_en ? w_rr_idx : w_fix_idx;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_id    = r_id;
        w_nxt_ptr   = r_ptr;
        w_nxt_hold  = r_hold;
        w_decide    = 1'b0;
        w_owner_req = |(req & r_grant);
        case (r_state)
            S_IDLE: begin
                if (|req) w_decide = 1'b1;
            end
            S_OWNED: begin
                if (!w_owner_req) begin
                    if (|w_cand) begin
                        w_decide = 1'b1;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_grant = '0;
                        w_nxt_id    = '0;
                        w_nxt_hold  = '0;
                    end
                end else if (MAX_HOLD != 0 && r_hold == HOLD_MAX && |w_cand) begin
                    w_decide = 1'b1;
                end else if (MAX_HOLD != 0 && r_hold != HOLD_MAX) begin
                    w_nxt_hold = r_hold + HC_W'(1);
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_grant = '0;
                w_nxt_id    = '0;
            end
        endcase
        if (w_decide) begin
            w_nxt_state = S_OWNED;
            w_nxt_grant = ONE << w_win_idx;
            w_nxt_id    = w_win_idx;
            w_nxt_ptr   = w_win_idx;
            w_nxt_hold  = HC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_id    <= '0;
            r_ptr   <= ID_W'(WIDTH - 1);
            r_hold  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_id    <= w_nxt_id;
            r_ptr   <= w_nxt_ptr;
            r_hold  <= w_nxt_hold;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = |r_grant;
    assign grant_id    = r_id;

endmodule
